// File: rtl/regfile_pkg.sv
// Shared types, defaults and the write-port priority encoder for regfile_mp.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  // Upper bound on write ports; wr_select works on a hit vector of this width.
  localparam int WR_MAX        = 3;

  typedef logic [XLEN_DEFAULT-1:0]           xlen_t;
  typedef logic [$clog2(NREGS_DEFAULT)-1:0]  reg_idx_t;

  // Highest-numbered set bit of the write-hit vector. Higher ports win
  // collisions, so the ascending scan lets later matches overwrite earlier.
  function automatic logic [1:0] wr_select(input logic [WR_MAX-1:0] hit);
    logic [1:0] sel;
    sel = '0;
    for (int p = 0; p < WR_MAX; p++) begin
      if (hit[p]) sel = 2'(p);
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write and reservation signals between core and regfile_mp.
// Latency: n/a (wires only).
// Backpressure: none; every field is sampled/driven every cycle.
//   master: issue/writeback side (drives indices, writes, reservations)
//   slave : register file (drives read data, pending flags, pend_any)
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = $clog2(NREGS_DEFAULT),
  parameter int NRD  = 2,
  parameter int NWR  = 2
) ();

  logic [NRD-1:0][AW-1:0]   rs_idx;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_pend;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   rd_idx;
  logic [NWR-1:0][XLEN-1:0] rd_data;
  logic                     rsv_valid;
  logic [AW-1:0]            rsv_idx;
  logic                     pend_any;

  modport master (
    output rs_idx, we, rd_idx, rd_data, rsv_valid, rsv_idx,
    input  rs_data, rs_pend, pend_any
  );

  modport slave (
    input  rs_idx, we, rd_idx, rd_data, rsv_valid, rsv_idx,
    output rs_data, rs_pend, pend_any
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage word + pending bit, with write bypass and x0 rule.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   in : rs_idx, word/pend_bit of the addressed register, all write ports
//   out: rs_data, rs_pend
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int AW       = 5,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]            rs_idx,
  input  logic [XLEN-1:0]          word,
  input  logic                     pend_bit,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   rd_idx,
  input  logic [NWR-1:0][XLEN-1:0] rd_data,
  output logic [XLEN-1:0]          rs_data,
  output logic                     rs_pend
);

  logic [WR_MAX-1:0] hit;
  logic [1:0]        sel;
  logic [XLEN-1:0]   fwd;

  always_comb begin
    hit = '0;
    for (int p = 0; p < NWR; p++) begin
      hit[p] = we[p] && (rd_idx[p] == rs_idx);
    end
  end

  assign sel = wr_select(hit);

  always_comb begin
    fwd = '0;
    for (int p = 0; p < NWR; p++) begin
      if (sel == 2'(p)) fwd = rd_data[p];
    end
  end

  // x0 takes precedence over bypass: a write to x0 must never become visible.
  always_comb begin
    rs_data = word;
    rs_pend = pend_bit;
    if (ZERO_REG != 0 && rs_idx == '0) begin
      rs_data = '0;
      rs_pend = 1'b0;
    end else if (BYPASS != 0 && (|hit)) begin
      rs_data = fwd;
      rs_pend = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending scoreboard.
// Latency: reads combinational; writes/reservations visible after the next edge (writes same cycle with BYPASS).
// Backpressure: none; every port accepted every cycle.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : regfile_mp_if slave (reads, writes, reservation, pend_any)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs, regs_nxt;
  logic [NREGS-1:0]           pend, pend_nxt;
  logic                       pend_any_q;
  logic [NRD-1:0][XLEN-1:0]   rs_data_w;
  logic [NRD-1:0]             rs_pend_w;

  // Ascending port order makes the highest-numbered colliding write win.
  // The reservation is applied last so it survives a same-cycle write:
  // it belongs to a newer producer than the one writing back.
  always_comb begin
    regs_nxt = regs;
    pend_nxt = pend;
    for (int p = 0; p < NWR; p++) begin
      if (bus.we[p] && !(ZERO_REG != 0 && bus.rd_idx[p] == '0)) begin
        regs_nxt[bus.rd_idx[p]] = bus.rd_data[p];
        pend_nxt[bus.rd_idx[p]] = 1'b0;
      end
    end
    if (bus.rsv_valid && !(ZERO_REG != 0 && bus.rsv_idx == '0)) begin
      pend_nxt[bus.rsv_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs       <= '0;
      pend       <= '0;
      pend_any_q <= 1'b0;
    end else begin
      regs       <= regs_nxt;
      pend       <= pend_nxt;
      pend_any_q <= |pend_nxt;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    regfile_rd_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rs_idx   (bus.rs_idx[r]),
      .word     (regs[bus.rs_idx[r]]),
      .pend_bit (pend[bus.rs_idx[r]]),
      .we       (bus.we),
      .rd_idx   (bus.rd_idx),
      .rd_data  (bus.rd_data),
      .rs_data  (rs_data_w[r]),
      .rs_pend  (rs_pend_w[r])
    );
  end

  assign bus.rs_data  = rs_data_w;
  assign bus.rs_pend  = rs_pend_w;
  assign bus.pend_any = pend_any_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus, fanned out to a BYPASS=1 and a BYPASS=0 instance.
  logic [1:0][4:0]  rs_idx;
  logic [1:0]       we;
  logic [1:0][4:0]  rd_idx;
  logic [1:0][31:0] rd_data;
  logic             rsv_valid;
  logic [4:0]       rsv_idx;

  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) ifc1 ();
  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) ifc0 ();

  assign ifc1.rs_idx = rs_idx;   assign ifc0.rs_idx = rs_idx;
  assign ifc1.we = we;           assign ifc0.we = we;
  assign ifc1.rd_idx = rd_idx;   assign ifc0.rd_idx = rd_idx;
  assign ifc1.rd_data = rd_data; assign ifc0.rd_data = rd_data;
  assign ifc1.rsv_valid = rsv_valid; assign ifc0.rsv_valid = rsv_valid;
  assign ifc1.rsv_idx = rsv_idx; assign ifc0.rsv_idx = rsv_idx;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1))
    dut1 (.clk(clk), .reset(reset), .bus(ifc1));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1))
    dut0 (.clk(clk), .reset(reset), .bus(ifc0));

  typedef struct {
    int          cyc;
    bit          which;   // 1 = bypass instance
    int          port;    // -1 = pend_any
    logic [31:0] data;
    logic        pend;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic exp_rd(input bit which, input int port, input logic [31:0] d,
                        input logic p, input string nm);
    exp_t e;
    e.cyc = cyc_cnt; e.which = which; e.port = port;
    e.data = d; e.pend = p; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_both(input int port, input logic [31:0] d, input logic p,
                          input string nm);
    exp_rd(1'b1, port, d, p, {nm, "_byp1"});
    exp_rd(1'b0, port, d, p, {nm, "_byp0"});
  endtask

  task automatic exp_any(input logic a, input string nm);
    exp_rd(1'b1, -1, 32'h0, a, {nm, "_byp1"});
    exp_rd(1'b0, -1, 32'h0, a, {nm, "_byp0"});
  endtask

  task automatic check(input exp_t e);
    logic [31:0] ad;
    logic        ap;
    n_cmp++;
    if (e.port < 0) begin
      ap = e.which ? ifc1.pend_any : ifc0.pend_any;
      if (ap !== e.pend) begin
        n_bad++;
        $display("FAIL %s: pend_any got %b want %b", e.name, ap, e.pend);
      end
    end else begin
      ad = e.which ? ifc1.rs_data[e.port] : ifc0.rs_data[e.port];
      ap = e.which ? ifc1.rs_pend[e.port] : ifc0.rs_pend[e.port];
      if (ad !== e.data || ap !== e.pend) begin
        n_bad++;
        $display("FAIL %s: port%0d got data=%h pend=%b want data=%h pend=%b",
                 e.name, e.port, ad, ap, e.data, e.pend);
      end
    end
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == cyc_cnt) check(exp_q[i]);
      else if (exp_q[i].cyc < cyc_cnt) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation never observed", exp_q[i].name);
      end else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; rsv_valid = 1'b0; rsv_idx = '0;
    rd_idx = '0; rd_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rs_idx = '0; idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state over every index on both ports.
    for (int i = 0; i < 32; i++) begin
      rs_idx[0] = 5'(i); rs_idx[1] = 5'(31 - i);
      exp_both(0, 32'h0, 1'b0, "reset_rd0");
      exp_both(1, 32'h0, 1'b0, "reset_rd1");
      exp_any(1'b0, "reset_any");
      step();
    end

    // Same-cycle bypass vs registered read.
    we[0] = 1'b1; rd_idx[0] = 5'd5; rd_data[0] = 32'hDEADBEEF; rs_idx[0] = 5'd5;
    exp_rd(1'b1, 0, 32'hDEADBEEF, 1'b0, "bypass_same_byp1");
    exp_rd(1'b0, 0, 32'h0,        1'b0, "bypass_same_byp0");
    step(); idle();
    exp_both(0, 32'hDEADBEEF, 1'b0, "bypass_next");
    step();

    // Write collision: highest port wins, stored and forwarded.
    we = 2'b11; rd_idx[0] = 5'd7; rd_idx[1] = 5'd7;
    rd_data[0] = 32'h11; rd_data[1] = 32'h22; rs_idx[1] = 5'd7;
    exp_rd(1'b1, 1, 32'h22, 1'b0, "collide_fwd_byp1");
    exp_rd(1'b0, 1, 32'h0,  1'b0, "collide_fwd_byp0");
    step(); idle();
    rs_idx[0] = 5'd7;
    exp_both(0, 32'h22, 1'b0, "collide_store0");
    exp_both(1, 32'h22, 1'b0, "collide_store1");
    step();

    // Index 0: write and reservation dropped.
    we[0] = 1'b1; rd_idx[0] = 5'd0; rd_data[0] = 32'hFFFFFFFF;
    rsv_valid = 1'b1; rsv_idx = 5'd0; rs_idx[0] = 5'd0;
    exp_both(0, 32'h0, 1'b0, "x0_same");
    step(); idle();
    exp_both(0, 32'h0, 1'b0, "x0_next");
    exp_any(1'b0, "x0_any");
    step();

    // Reserve index 3: not forwarded, visible next cycle.
    rsv_valid = 1'b1; rsv_idx = 5'd3; rs_idx[0] = 5'd3;
    exp_both(0, 32'h0, 1'b0, "rsv_same");
    step(); idle();
    exp_both(0, 32'h0, 1'b1, "rsv_next");
    exp_any(1'b1, "rsv_any");
    step();

    // Writeback to 3 clears pending (same cycle only with bypass).
    we[1] = 1'b1; rd_idx[1] = 5'd3; rd_data[1] = 32'h33;
    exp_rd(1'b1, 0, 32'h33, 1'b0, "wb_same_byp1");
    exp_rd(1'b0, 0, 32'h0,  1'b1, "wb_same_byp0");
    exp_any(1'b1, "wb_same_any");
    step(); idle();
    exp_both(0, 32'h33, 1'b0, "wb_next");
    exp_any(1'b0, "wb_next_any");
    step();

    // Reserve and write 3 together: data updated, pending stays set.
    rsv_valid = 1'b1; rsv_idx = 5'd3;
    we[0] = 1'b1; rd_idx[0] = 5'd3; rd_data[0] = 32'h44;
    exp_rd(1'b1, 0, 32'h44, 1'b0, "rsvwr_same_byp1");
    exp_rd(1'b0, 0, 32'h33, 1'b0, "rsvwr_same_byp0");
    step(); idle();
    exp_both(0, 32'h44, 1'b1, "rsvwr_next");
    exp_any(1'b1, "rsvwr_any");
    step();

    // Reset mid-operation.
    rsv_valid = 1'b1; rsv_idx = 5'd9;
    we[0] = 1'b1; rd_idx[0] = 5'd4; rd_data[0] = 32'h55;
    step(); idle();
    rs_idx[0] = 5'd4; rs_idx[1] = 5'd9;
    exp_both(0, 32'h55, 1'b0, "pre_rst_r4");
    exp_both(1, 32'h0,  1'b1, "pre_rst_r9");
    exp_any(1'b1, "pre_rst_any");
    step();
    reset = 1'b1;
    we[0] = 1'b1; rd_idx[0] = 5'd4; rd_data[0] = 32'hAA;
    exp_rd(1'b1, 0, 32'hAA, 1'b0, "rst_cyc_byp1");
    exp_rd(1'b0, 0, 32'h55, 1'b0, "rst_cyc_byp0");
    step(); idle(); reset = 1'b0;
    exp_both(0, 32'h0, 1'b0, "post_rst_r4");
    exp_both(1, 32'h0, 1'b0, "post_rst_r9");
    exp_any(1'b0, "post_rst_any");
    step();
    rs_idx[0] = 5'd3; rs_idx[1] = 5'd5;
    exp_both(0, 32'h0, 1'b0, "post_rst_r3");
    exp_both(1, 32'h0, 1'b0, "post_rst_r5");
    step();

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
